adc083000_spi_ctrl: RTL and testbench
=====================================

# adc083000_spi_ctrl

Sequences register writes into one or two ADC083000 boards over their 3-wire serial interface (notSCS, SCLK, SDATA). Sits on the sys_clk side next to the ADC board PHYs. Accepts one write request at a time from the software-register bridge, serialises a 32-bit frame to the selected board(s), and arbitrates both boards onto a single frame engine. Selecting both boards in one request broadcasts the frame.

## Interface
Parameters:
- CLK_DIV, 4: sys_clk cycles per SCLK half-period; legal range ≥1.
- GAP_CYCLES, 8: minimum notSCS-high cycles between frames; legal range ≥1.

Ports:
- sys_clk  in  1  sole clock; all logic on its rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  write request present.
- req_ready  out  1  high = request accepted on this edge if req_valid is high.
- req_adc_sel  in  2  bit0 selects ADC0, bit1 selects ADC1; 2'b11 broadcasts.
- req_addr  in  4  ADC register address.
- req_data  in  16  register value.
- busy  out  1  equals ~req_ready.
- done  out  1  one-cycle pulse at frame completion.
- adc0_notSCS / adc1_notSCS  out  1  chip selects, active-low.
- adc0_sclk / adc1_sclk  out  1  serial clocks.
- adc0_sdata / adc1_sdata  out  1  serial data, MSB first.
- shadow_adc  in  1  shadow read select (ADC_SPI_SHADOW_EN only).
- shadow_addr  in  4  shadow read address (ADC_SPI_SHADOW_EN only).
- shadow_data  out  16  shadow read data (ADC_SPI_SHADOW_EN only).

## Operation
- Frame format: {12'h001, req_addr, req_data} = 32 bits, shifted MSB first.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid with req_ready: capture the frame and the selection, then go to SHIFT.
  - If req_adc_sel==0: accept the request, emit no frame, pulse done on the next cycle, and stay in IDLE.
- SHIFT: 32 bits. Each bit occupies CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high. SDATA changes only while SCLK is low, at the start of the bit; the ADC samples on the SCLK rising edge.
- HOLD: CLK_DIV cycles with SCLK low, notSCS still low, SDATA 0.
- GAP: GAP_CYCLES cycles with notSCS high. done pulses in the last GAP cycle; the FSM returns to IDLE on the next cycle.
- Unselected board: notSCS=1, SCLK=0, SDATA=0 for the whole frame.
- Selected boards are driven with identical waveforms.
- req_valid held during a frame: ignored until IDLE. No queuing. The requester holds its request stable until accepted.

## Timing
- All serial outputs are registered; no combinational path from inputs to pins.
- Accept edge = T0. notSCS falls at T0+1 and stays low for 65×CLK_DIV cycles.
- With defaults:
  - notSCS low T0+1..T0+260.
  - done at T0+268.
  - req_ready=1 again at T0+269.
  - Earliest next notSCS fall is T0+270.
- Reset values: notSCS=1, SCLK=0, SDATA=0, done=0, req_ready=1, busy=0, state=IDLE, shadow=16'h0000 for all entries.
- Reset asserted mid-frame: outputs take their reset values immediately (asynchronous). The frame is aborted, done does not pulse, and the shadow is not updated.
- Counters:
  - Phase counter width = $clog2(max(CLK_DIV,GAP_CYCLES)+1).
  - Bit counter is 5 bits. It counts 31 down to 0; the frame ends after the high phase of bit 0. Wrap-around is not used.

## Configuration
- ADC_SPI_SHADOW_EN defined: the block holds a 2×16×16-bit shadow of the last value written per board and address.
  - The shadow is updated in the cycle done pulses, for every selected board.
  - shadow_data is registered and appears one cycle after shadow_adc/shadow_addr are presented.
  - A read of an address whose update lands in the same cycle returns the old value.
- ADC_SPI_SHADOW_EN undefined: shadow ports are absent and no storage is instantiated.

## Structure
- adc083000_spi_pkg holds:
  - FRAME_HEADER=12'h001 and FRAME_BITS=32.
  - The state enum (IDLE, SHIFT, HOLD, GAP).
  - A request struct {sel[1:0], addr[3:0], data[15:0]}.
- The shadow store is a natural sub-module, adc083000_spi_shadow, instantiated only under ADC_SPI_SHADOW_EN.

## Test plan
- ADC0 write, addr 0x1, data 0xB2FF, defaults:
  - adc0_sdata sampled on SCLK rising edges = 32'h0011B2FF.
  - adc0 sees 32 rising edges; adc0_notSCS low for 260 cycles.
  - adc1 pins idle.
  - done at T0+268.
- Broadcast (sel=2'b11), addr 0xF, data 0x0001: adc0 and adc1 pins are bit-identical every cycle; frame = 32'h001F0001.
- Back-to-back, second req_valid held from T0+1: req_ready=0 until T0+269; second accept at T0+269; gap of notSCS high ≥8 cycles.
- sel=0: accepted at T0, done at T0+1, no notSCS activity, req_ready remains 1.
- sys_rst_n low at T0+100 of a frame: notSCS=1 and SCLK=0 in the same cycle; no done pulse; the next request after reset produces a full correct frame.
- ADC_SPI_SHADOW_EN:
  - Write ADC1 addr 0x3, data 0x7FFF; then reading shadow_adc=1, shadow_addr=3 returns 0x7FFF one cycle later.
  - Reading ADC0 addr 3 returns 0x0000.

Source files
------------

// File: rtl/adc083000_spi_pkg.sv
// adc083000_spi_pkg: shared types and constants for the ADC083000 3-wire
// serial register-write controller.
//   FRAME_HEADER / FRAME_BITS : fixed frame layout {header, addr, data}
//   state_e                   : frame engine states
//   req_t                     : captured write request
//   build_frame()             : assembles the 32-bit frame from a request
package adc083000_spi_pkg;

  localparam logic [11:0] FRAME_HEADER = 12'h001;
  localparam int unsigned FRAME_BITS   = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  typedef struct packed {
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic [15:0] data;
  } req_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(input req_t r);
    return {FRAME_HEADER, r.addr, r.data};
  endfunction

endpackage

// File: rtl/adc083000_spi_shadow.sv
// adc083000_spi_shadow: 2 boards x 16 addresses x 16-bit copy of the last
// value written to each ADC register.
//   clk_i, rst_ni     : clock, asynchronous active-low reset (clears store)
//   wr_en_i           : write strobe (frame completion)
//   wr_sel_i          : per-board write enables, bit0 = ADC0, bit1 = ADC1
//   wr_addr_i/data_i  : register address and value written
//   rd_adc_i/addr_i   : read select
//   rd_data_o         : registered read data, one cycle after the select;
//                       a write landing on the same edge returns old data
module adc083000_spi_shadow (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_sel_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [15:0] wr_data_i,
  input  logic        rd_adc_i,
  input  logic [3:0]  rd_addr_i,
  output logic [15:0] rd_data_o
);

  logic [15:0] mem_q [2][16];
  logic [15:0] rd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned a = 0; a < 16; a++) begin
          mem_q[b][a] <= '0;
        end
      end
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_adc_i][rd_addr_i];
      for (int unsigned b = 0; b < 2; b++) begin
        if (wr_en_i && wr_sel_i[b]) begin
          mem_q[b][wr_addr_i] <= wr_data_i;
        end
      end
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/adc083000_spi_ctrl.sv
// adc083000_spi_ctrl: serialises 32-bit register-write frames
// {12'h001, addr, data} MSB first onto one or both ADC083000 boards over
// their 3-wire interface (notSCS, SCLK, SDATA).
//   sys_clk, sys_rst_n      : clock, asynchronous active-low reset
//   req_valid/req_ready     : one-at-a-time write request handshake
//   req_adc_sel/addr/data   : board select (2'b11 broadcasts), address, value
//   busy                    : ~req_ready
//   done                    : one-cycle pulse at frame completion
//   adcN_notSCS/sclk/sdata  : registered serial pins for board N
//   shadow_adc/addr/data    : shadow read port, present only when
//                             ADC_SPI_SHADOW_EN is defined
// Parameters: CLK_DIV (sys_clk cycles per SCLK half-period, >=1),
//             GAP_CYCLES (notSCS-high cycles between frames, >=1).
module adc083000_spi_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_adc_sel,
  input  logic [3:0]  req_addr,
  input  logic [15:0] req_data,
  output logic        busy,
  output logic        done,
  output logic        adc0_notSCS,
  output logic        adc1_notSCS,
  output logic        adc0_sclk,
  output logic        adc1_sclk,
  output logic        adc0_sdata,
  output logic        adc1_sdata
`ifdef ADC_SPI_SHADOW_EN
  ,
  input  logic        shadow_adc,
  input  logic [3:0]  shadow_addr,
  output logic [15:0] shadow_data
`endif
);

  import adc083000_spi_pkg::*;

  localparam int unsigned PH_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] DIV_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_CYCLES - 1);

  state_e               state_q;
  req_t                 req_q;
  req_t                 req_d;
  logic [4:0]           bit_q;
  logic [PH_W-1:0]      phase_q;
  logic                 sclk_hi_q;
  logic                 ready_q;
  logic                 done_q;
  logic [1:0]           cs_n_q;
  logic [1:0]           sclk_q;
  logic [1:0]           sdata_q;
  logic [FRAME_BITS-1:0] frame_in;
  logic [FRAME_BITS-1:0] frame_cur;

  always_comb begin
    req_d      = '0;
    req_d.sel  = req_adc_sel;
    req_d.addr = req_addr;
    req_d.data = req_data;
    frame_in   = build_frame(req_d);
    frame_cur  = build_frame(req_q);
  end

  // Pins are updated on the same edge as the state change, so the first
  // bit is already on SDATA with notSCS low right after the accept edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      bit_q     <= '0;
      phase_q   <= '0;
      sclk_hi_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      cs_n_q    <= '1;
      sclk_q    <= '0;
      sdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q <= req_d;
            if (req_adc_sel == 2'b00) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= SHIFT;
              ready_q   <= 1'b0;
              bit_q     <= 5'd31;
              phase_q   <= '0;
              sclk_hi_q <= 1'b0;
              cs_n_q    <= ~req_adc_sel;
              sdata_q   <= req_adc_sel & {2{frame_in[FRAME_BITS-1]}};
            end
          end
        end
        SHIFT: begin
          if (phase_q == DIV_LAST) begin
            phase_q <= '0;
            if (!sclk_hi_q) begin
              sclk_hi_q <= 1'b1;
              sclk_q    <= req_q.sel;
            end else begin
              sclk_hi_q <= 1'b0;
              sclk_q    <= '0;
              if (bit_q == 5'd0) begin
                state_q <= HOLD;
                sdata_q <= '0;
              end else begin
                bit_q   <= bit_q - 5'd1;
                sdata_q <= req_q.sel & {2{frame_cur[bit_q - 5'd1]}};
              end
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        HOLD: begin
          if (phase_q == DIV_LAST) begin
            state_q <= GAP;
            phase_q <= '0;
            cs_n_q  <= '1;
            done_q  <= (GAP_CYCLES == 1);
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        GAP: begin
          if (phase_q == GAP_LAST) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            phase_q <= phase_q + PH_W'(1);
            // done is registered, so raise it on entry to the last GAP cycle
            done_q  <= ((phase_q + PH_W'(1)) == GAP_LAST);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign busy        = ~ready_q;
  assign done        = done_q;
  assign adc0_notSCS = cs_n_q[0];
  assign adc1_notSCS = cs_n_q[1];
  assign adc0_sclk   = sclk_q[0];
  assign adc1_sclk   = sclk_q[1];
  assign adc0_sdata  = sdata_q[0];
  assign adc1_sdata  = sdata_q[1];

`ifdef ADC_SPI_SHADOW_EN
  adc083000_spi_shadow u_shadow (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .wr_en_i   (done_q),
    .wr_sel_i  (req_q.sel),
    .wr_addr_i (req_q.addr),
    .wr_data_i (req_q.data),
    .rd_adc_i  (shadow_adc),
    .rd_addr_i (shadow_addr),
    .rd_data_o (shadow_data)
  );
`endif

endmodule

// File: tb/tb_adc083000_spi_ctrl.sv
// tb_adc083000_spi_ctrl: bench for adc083000_spi_ctrl. A negedge monitor
// rebuilds each frame from the pins and compares it with a queue of accepted
// requests. Time convention: "Tn" is the rising edge that samples a value,
// so an observation made at the negedge after edge cyc belongs to T(cyc+1).
// Shadow checks are compiled in when ADC_SPI_SHADOW_EN is defined.
module tb_adc083000_spi_ctrl;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 8;
  localparam int unsigned CS_LOW     = 65 * CLK_DIV;
  localparam int unsigned DONE_OFS   = CS_LOW + GAP_CYCLES;
  localparam int unsigned BUDGET     = 2000;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_adc_sel;
  logic [3:0]  req_addr;
  logic [15:0] req_data;
  logic        busy;
  logic        done;
  logic        adc0_notSCS, adc1_notSCS;
  logic        adc0_sclk, adc1_sclk;
  logic        adc0_sdata, adc1_sdata;
`ifdef ADC_SPI_SHADOW_EN
  logic        shadow_adc;
  logic [3:0]  shadow_addr;
  logic [15:0] shadow_data;
  logic [15:0] sh_m [2][16];
`endif

  adc083000_spi_ctrl #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_adc_sel (req_adc_sel),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .busy        (busy),
    .done        (done),
    .adc0_notSCS (adc0_notSCS),
    .adc1_notSCS (adc1_notSCS),
    .adc0_sclk   (adc0_sclk),
    .adc1_sclk   (adc1_sclk),
    .adc0_sdata  (adc0_sdata),
    .adc1_sdata  (adc1_sdata)
`ifdef ADC_SPI_SHADOW_EN
    ,
    .shadow_adc  (shadow_adc),
    .shadow_addr (shadow_addr),
    .shadow_data (shadow_data)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc = cyc + 1;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic [15:0] data;
    int unsigned t0;
  } txn_t;

  txn_t q[$];

  logic [1:0]  cs, sck, sd;
  assign cs  = {adc1_notSCS, adc0_notSCS};
  assign sck = {adc1_sclk, adc0_sclk};
  assign sd  = {adc1_sdata, adc0_sdata};

  logic [31:0] cap [2];
  logic [31:0] last_cap [2];
  int unsigned rises [2];
  int unsigned low_cnt [2];
  int unsigned hi_run [2];
  int unsigned cs_high_run [2];
  bit          had_frame [2];
  bit          frame_done [2];
  logic        prev_cs [2];
  logic        prev_sck [2];
  logic        prev_sd [2];
  int unsigned last_done_s;
  int unsigned s_m;
  logic        exp_rdy;
  bit          sel_b;
  txn_t        tn;

  // Reference monitor: expected frames and timing come from the request
  // queue and the frame rule {12'h001, addr, data}.
  always @(negedge sys_clk) begin
    s_m = cyc + 1;
    if (!sys_rst_n) begin
      check_val("rst_cs", {30'd0, cs}, 32'h3);
      check_val("rst_sclk_sdata", {28'd0, sck, sd}, 32'h0);
      check_val("rst_done", {31'd0, done}, 32'h0);
      check_val("rst_ready", {31'd0, req_ready}, 32'h1);
      q.delete();
      for (int b = 0; b < 2; b++) begin
        rises[b] = 0; low_cnt[b] = 0; hi_run[b] = 0; cs_high_run[b] = 0;
        had_frame[b] = 0; frame_done[b] = 0;
        prev_cs[b] = 1'b1; prev_sck[b] = 1'b0; prev_sd[b] = 1'b0;
      end
`ifdef ADC_SPI_SHADOW_EN
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 16; a++) sh_m[b][a] = 16'h0000;
`endif
    end else begin
      exp_rdy = !(q.size() > 0 && q[0].sel != 2'b00);
      check_val("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
      check_val("busy", {31'd0, busy}, {31'd0, !exp_rdy});
      for (int b = 0; b < 2; b++) begin
        sel_b = (q.size() > 0) && q[0].sel[b];
        if (!sel_b) begin
          check_val($sformatf("idle_pins%0d", b), {29'd0, cs[b], sck[b], sd[b]}, 32'h4);
        end else if (!cs[b]) begin
          if (prev_cs[b]) begin
            if (had_frame[b]) check_val($sformatf("gap%0d", b), {31'd0, cs_high_run[b] >= GAP_CYCLES}, 32'h1);
            check_val($sformatf("cs_fall%0d", b), s_m - q[0].t0, 32'd1);
            rises[b] = 0; low_cnt[b] = 0; hi_run[b] = 0; cap[b] = '0;
          end
          low_cnt[b] = low_cnt[b] + 1;
          if (sck[b] && !prev_sck[b]) begin
            rises[b] = rises[b] + 1;
            cap[b] = {cap[b][30:0], sd[b]};
          end
          if (sck[b]) hi_run[b] = hi_run[b] + 1;
          else if (prev_sck[b]) begin
            check_val($sformatf("sclk_high%0d", b), hi_run[b], CLK_DIV);
            hi_run[b] = 0;
          end
          if (sd[b] !== prev_sd[b]) check_val($sformatf("sdata_chg%0d", b), {31'd0, sck[b]}, 32'h0);
        end else begin
          check_val($sformatf("cs_hi_quiet%0d", b), {30'd0, sck[b], sd[b]}, 32'h0);
          if (!prev_cs[b]) begin
            check_val($sformatf("frame%0d", b), cap[b], {12'h001, q[0].addr, q[0].data});
            check_val($sformatf("rises%0d", b), rises[b], 32'd32);
            check_val($sformatf("cs_low%0d", b), low_cnt[b], CS_LOW);
            last_cap[b] = cap[b];
            frame_done[b] = 1;
            had_frame[b] = 1;
          end
        end
        if (cs[b]) cs_high_run[b] = cs_high_run[b] + 1;
        else cs_high_run[b] = 0;
        prev_cs[b] = cs[b]; prev_sck[b] = sck[b]; prev_sd[b] = sd[b];
      end
      if (q.size() > 0 && q[0].sel == 2'b11)
        check_val("bcast_same", {29'd0, cs[0], sck[0], sd[0]}, {29'd0, cs[1], sck[1], sd[1]});
      if (done) begin
        if (q.size() == 0) begin
          check_val("done_unexpected", {31'd0, done}, 32'h0);
        end else begin
          check_val("done_lat", s_m - q[0].t0, (q[0].sel == 2'b00) ? 32'd1 : DONE_OFS);
          for (int b = 0; b < 2; b++)
            if (q[0].sel[b]) check_val($sformatf("frame_seen%0d", b), {31'd0, frame_done[b]}, 32'h1);
`ifdef ADC_SPI_SHADOW_EN
          for (int b = 0; b < 2; b++)
            if (q[0].sel[b]) sh_m[b][q[0].addr] = q[0].data;
`endif
          last_done_s = s_m;
          void'(q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        tn.sel = req_adc_sel; tn.addr = req_addr; tn.data = req_data; tn.t0 = s_m;
        q.push_back(tn);
        frame_done[0] = 0; frame_done[1] = 0;
      end
    end
  end

  task automatic send(input logic [1:0] sel, input logic [3:0] a, input logic [15:0] d,
                      output int unsigned t0);
    int unsigned n;
    bit ok;
    n = 0; ok = 0; t0 = 0;
    req_valid = 1'b1; req_adc_sel = sel; req_addr = a; req_data = d;
    while (n < BUDGET) begin
      @(negedge sys_clk);
      if (req_ready) begin ok = 1; break; end
      n = n + 1;
    end
    if (!ok) check_val("accept_timeout", {31'd0, req_ready}, 32'h1);
    t0 = cyc + 1;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (n < BUDGET) begin
      @(posedge sys_clk); #1;
      if (q.size() == 0 && req_ready) break;
      n = n + 1;
    end
    if (n >= BUDGET) check_val("idle_timeout", q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned t0, t0b;

  initial begin
    sys_rst_n = 1'b0;
    req_valid = 1'b0; req_adc_sel = '0; req_addr = '0; req_data = '0;
`ifdef ADC_SPI_SHADOW_EN
    shadow_adc = 1'b0; shadow_addr = '0;
`endif
    repeat (3) @(negedge sys_clk);
    check_val("reset_state", {25'd0, cs, sck, sd, done}, 32'h60);
    #3 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // ADC0 single write
    send(2'b01, 4'h1, 16'hB2FF, t0);
    wait_idle();
    check_val("adc0_frame", last_cap[0], 32'h0011B2FF);
    check_val("adc0_done_at", last_done_s - t0, 32'd268);

    // Broadcast
    send(2'b11, 4'hF, 16'h0001, t0);
    wait_idle();
    check_val("bcast_frame0", last_cap[0], 32'h001F0001);
    check_val("bcast_frame1", last_cap[1], 32'h001F0001);

    // Back-to-back: second request held from T0+1
    send(2'b01, 4'h2, 16'h1234, t0);
    send(2'b10, 4'h5, 16'hABCD, t0b);
    check_val("b2b_accept", t0b - t0, 32'd269);
    wait_idle();
    check_val("b2b_frame1", last_cap[1], 32'h0015ABCD);

    // sel = 0: done on the next cycle, no pin activity
    send(2'b00, 4'h7, 16'h5555, t0);
    @(negedge sys_clk);
    check_val("sel0_done", {31'd0, done}, 32'h1);
    check_val("sel0_ready", {31'd0, req_ready}, 32'h1);
    check_val("sel0_cs", {30'd0, cs}, 32'h3);
    @(posedge sys_clk); #1;

    // Reset mid-frame
    send(2'b01, 4'h9, 16'hC3A5, t0);
    repeat (99) @(posedge sys_clk);
    #2;
    check_val("pre_rst_cs", {31'd0, cs[0]}, 32'h0);
    sys_rst_n = 1'b0;
    #1;
    check_val("rst_async_cs", {30'd0, cs}, 32'h3);
    check_val("rst_async_sclk", {30'd0, sck}, 32'h0);
    repeat (3) @(negedge sys_clk);
    #3 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    send(2'b01, 4'h9, 16'hC3A5, t0);
    wait_idle();
    check_val("post_rst_frame", last_cap[0], 32'h0019C3A5);

`ifdef ADC_SPI_SHADOW_EN
    send(2'b10, 4'h3, 16'h7FFF, t0);
    wait_idle();
    shadow_adc = 1'b1; shadow_addr = 4'h3;
    @(posedge sys_clk); #1;
    check_val("shadow_adc1_a3", {16'd0, shadow_data}, 32'h7FFF);
    shadow_adc = 1'b0;
    @(posedge sys_clk); #1;
    check_val("shadow_adc0_a3", {16'd0, shadow_data}, 32'h0000);
`endif

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom), 16'($urandom), t0);
      repeat ($urandom_range(0, 4)) @(posedge sys_clk);
      #1;
    end
    wait_idle();

`ifdef ADC_SPI_SHADOW_EN
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 16; a++) begin
        shadow_adc = b[0]; shadow_addr = 4'(a);
        @(posedge sys_clk); #1;
        check_val($sformatf("shadow_%0d_%0d", b, a), {16'd0, shadow_data}, {16'd0, sh_m[b][a]});
      end
    end
`endif

    repeat (4) @(posedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
